// File: rtl/rc4_ks_sched_if.sv
// Bus bundle between software/requesters/RC4 core and the rc4_ks_sched controller.
// slave: the controller side; master: the environment driving it.
interface rc4_ks_sched_if #(
    parameter int NREQ = 2,
    parameter int KW   = 10
);
    logic            key_wr;
    logic [7:0]      key_data;
    logic            key_start;
    logic            core_rst;
    logic [7:0]      core_pw;
    logic            core_ready;
    logic [KW-1:0]   core_k;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [KW-1:0]   ks_data;
    logic            busy;
    logic            ready;
    logic            ovf;
    logic            err;

    modport slave (
        input  key_wr, key_data, key_start, core_ready, core_k, req,
        output core_rst, core_pw, gnt, ks_data, busy, ready, ovf, err
    );

    modport master (
        output key_wr, key_data, key_start, core_ready, core_k, req,
        input  core_rst, core_pw, gnt, ks_data, busy, ready, ovf, err
    );
endinterface

// File: rtl/rc4_ks_sched.sv
// rc4_ks_sched: key buffer, RC4 core sequencer, keystream FIFO and
// round-robin arbiter for NREQ requesters.
// Optional WAIT-state watchdog enabled by defining RC4_KS_SCHED_TIMEOUT_EN.
module rc4_ks_sched #(
    parameter int KEY_SIZE    = 16,
    parameter int NREQ        = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int KW          = 10,
    parameter int TIMEOUT_CYC = 4095
) (
    input logic           clk,
    input logic           rst,
    rc4_ks_sched_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_RKEY = 3'd4;  // one-cycle core reset before a rekey LOAD

    localparam int WPW = $clog2(KEY_SIZE + 1);
    localparam int LCW = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int RPW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NR = NREQ;

    localparam logic [WPW-1:0] WP_FULL = WPW'(KEY_SIZE);
    localparam logic [LCW-1:0] LC_LAST = LCW'(KEY_SIZE - 1);
    localparam logic [AW:0]    F_FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [RPW-1:0] RR_LAST = RPW'(NREQ - 1);

    logic [2:0]      state;
    logic            core_rst_q;
    logic [7:0]      keybuf [KEY_SIZE];
    logic [WPW-1:0]  wptr;
    logic [LCW-1:0]  lcnt;
    logic [KW-1:0]   fifo [FIFO_DEPTH];
    logic [AW-1:0]   fhead;
    logic [AW-1:0]   ftail;
    logic [AW:0]     flevel;
    logic            ovf_q;
    logic            err_q;
    logic [RPW-1:0]  rr;

    logic            start_ok;
    logic            key_accept;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic            fifo_we;
    logic            timeout;
    logic [NREQ-1:0] gnt_c;
    logic [RPW-1:0]  gnt_idx;
    logic            found;
    int unsigned     idx;

    assign start_ok   = bus.key_start && (wptr == WP_FULL) &&
                        (state != S_LOAD) && (state != S_RKEY);
    assign key_accept = bus.key_wr && (wptr != WP_FULL) &&
                        (state != S_LOAD) && (state != S_RKEY);
    assign empty      = (flevel == '0);
    assign full       = (flevel == F_FULL);
    assign push       = bus.core_ready && ((state == S_WAIT) || (state == S_RUN)) &&
                        !start_ok && !timeout;
    assign pop        = |gnt_c;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign fifo_we    = push && (!full || pop);

`ifdef RC4_KS_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wd_cnt;

    assign timeout = (state == S_WAIT) && !bus.core_ready && !start_ok &&
                     (wd_cnt == TW'(TIMEOUT_CYC - 1));

    // Watchdog: count WAIT cycles without core_ready; err is sticky until a rekey.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else if (start_ok) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else if (timeout) begin
            wd_cnt <= '0;
            err_q  <= 1'b1;
        end else if ((state == S_WAIT) && !bus.core_ready) begin
            wd_cnt <= wd_cnt + TW'(1);
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_q   = 1'b0;
`endif

    // Sequencer: owns the core reset and walks the key bytes into the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            core_rst_q <= 1'b1;
            lcnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state      <= S_LOAD;
                        core_rst_q <= 1'b0;
                        lcnt       <= '0;
                    end
                end
                S_LOAD: begin
                    if (lcnt == LC_LAST) begin
                        state <= S_WAIT;
                    end else begin
                        lcnt <= lcnt + LCW'(1);
                    end
                end
                S_WAIT: begin
                    if (start_ok) begin
                        state      <= S_RKEY;
                        core_rst_q <= 1'b1;
                    end else if (bus.core_ready) begin
                        state <= S_RUN;
                    end else if (timeout) begin
                        state      <= S_IDLE;
                        core_rst_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (start_ok) begin
                        state      <= S_RKEY;
                        core_rst_q <= 1'b1;
                    end
                end
                S_RKEY: begin
                    state      <= S_LOAD;
                    core_rst_q <= 1'b0;
                    lcnt       <= '0;
                end
                default: begin
                    state      <= S_IDLE;
                    core_rst_q <= 1'b1;
                end
            endcase
        end
    end

    // Key write pointer: saturates at KEY_SIZE, rewound by a honoured start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
        end else if (start_ok) begin
            wptr <= '0;
        end else if (key_accept) begin
            wptr <= wptr + WPW'(1);
        end
    end

    // Key storage: contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (key_accept) begin
            keybuf[wptr[LCW-1:0]] <= bus.key_data;
        end
    end

    // FIFO pointers, level and sticky overflow; a honoured start flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fhead  <= '0;
            ftail  <= '0;
            flevel <= '0;
            ovf_q  <= 1'b0;
        end else if (start_ok) begin
            fhead  <= '0;
            ftail  <= '0;
            flevel <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (pop) begin
                fhead <= fhead + AW'(1);
            end
            if (fifo_we) begin
                ftail <= ftail + AW'(1);
            end
            if (fifo_we && !pop) begin
                flevel <= flevel + (AW + 1)'(1);
            end else if (pop && !fifo_we) begin
                flevel <= flevel - (AW + 1)'(1);
            end
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (fifo_we) begin
            fifo[ftail] <= bus.core_k;
        end
    end

    // Round-robin search starting at rr; first set request wins.
    always_comb begin
        gnt_c   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        if ((state == S_RUN) && !empty) begin
            for (int unsigned i = 0; i < NR; i++) begin
                idx = i + 32'(rr);
                if (idx >= NR) begin
                    idx = idx - NR;
                end
                if (!found && bus.req[RPW'(idx)]) begin
                    found                = 1'b1;
                    gnt_c[RPW'(idx)]     = 1'b1;
                    gnt_idx              = RPW'(idx);
                end
            end
        end
    end

    // Round-robin pointer moves past the most recent winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr <= '0;
        end else if (pop) begin
            rr <= (gnt_idx == RR_LAST) ? '0 : gnt_idx + RPW'(1);
        end
    end

    assign bus.core_rst = core_rst_q;
    assign bus.core_pw  = (state == S_LOAD) ? keybuf[lcnt] : 8'h00;
    assign bus.gnt      = gnt_c;
    assign bus.ks_data  = fifo[fhead];
    assign bus.busy     = (state == S_LOAD) || (state == S_WAIT) || (state == S_RKEY);
    assign bus.ready    = (state == S_RUN);
    assign bus.ovf      = ovf_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_rc4_ks_sched.sv
// Testbench for rc4_ks_sched: directed scenarios plus a randomized run
// against a queue-based keystream/arbitration model. Inputs change on the
// falling edge and outputs are sampled 1 ns later.
module tb_rc4_ks_sched;
    localparam int KEY_SIZE    = 16;
    localparam int NREQ        = 2;
    localparam int FIFO_DEPTH  = 8;
    localparam int KW          = 10;
    localparam int TIMEOUT_CYC = 4095;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] key_img [KEY_SIZE];

    always #5 clk = ~clk;

    rc4_ks_sched_if #(.NREQ(NREQ), .KW(KW)) bus ();

    rc4_ks_sched #(
        .KEY_SIZE(KEY_SIZE),
        .NREQ(NREQ),
        .FIFO_DEPTH(FIFO_DEPTH),
        .KW(KW),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic idle_inputs();
        bus.key_wr     = 1'b0;
        bus.key_data   = 8'h00;
        bus.key_start  = 1'b0;
        bus.core_ready = 1'b0;
        bus.core_k     = '0;
        bus.req        = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Writes key_img into the key buffer, one byte per cycle; key_wr left high.
    task automatic write_key_img();
        for (int i = 0; i < KEY_SIZE; i++) begin
            @(negedge clk);
            bus.key_wr   = 1'b1;
            bus.key_data = key_img[i];
        end
    endtask

    // Reset, load a random key, and hand the first word over in WAIT.
    task automatic bring_up(input logic [KW-1:0] first);
        do_reset();
        for (int i = 0; i < KEY_SIZE; i++) key_img[i] = 8'($urandom);
        write_key_img();
        @(negedge clk);
        bus.key_wr    = 1'b0;
        bus.key_start = 1'b1;
        repeat (KEY_SIZE) begin
            @(negedge clk);
            bus.key_start = 1'b0;
        end
        @(negedge clk);
        bus.core_ready = 1'b1;
        bus.core_k     = first;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++; if (bus.core_rst !== 1'b1) begin fails++; $display("FAIL reset_core_rst: got %b expected 1", bus.core_rst); end
        tests++; if (bus.core_pw !== 8'h00) begin fails++; $display("FAIL reset_core_pw: got %h expected 00", bus.core_pw); end
        tests++; if (bus.gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b expected 00", bus.gnt); end
        tests++; if ({bus.busy, bus.ready, bus.ovf, bus.err} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got busy/ready/ovf/err=%b expected 0000", {bus.busy, bus.ready, bus.ovf, bus.err}); end

        // Asynchronous reset in the middle of a RUN cycle with data buffered.
        bring_up(10'h155);
        @(negedge clk);
        bus.core_ready = 1'b1;
        bus.core_k     = 10'h0AA;
        @(negedge clk);
        bus.core_ready = 1'b0;
        bus.req        = 2'b11;
        #1;
        tests++; if (bus.gnt !== 2'b01) begin fails++; $display("FAIL midrst_pre_gnt: got %b expected 01", bus.gnt); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (bus.core_rst !== 1'b1) begin fails++; $display("FAIL midrst_core_rst: got %b expected 1", bus.core_rst); end
        tests++; if (bus.gnt !== 2'b00) begin fails++; $display("FAIL midrst_gnt: got %b expected 00", bus.gnt); end
        tests++; if ({bus.busy, bus.ready, bus.ovf} !== 3'b000) begin fails++; $display("FAIL midrst_flags: got busy/ready/ovf=%b expected 000", {bus.busy, bus.ready, bus.ovf}); end

        // Write pointer is back at zero, so a start without a rewrite is ignored.
        @(negedge clk);
        rst           = 1'b0;
        bus.req       = '0;
        bus.key_start = 1'b1;
        @(negedge clk);
        bus.key_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            tests++; if (bus.core_rst !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_start_ignored: got core_rst=%b busy=%b expected 1 0", bus.core_rst, bus.busy); end
        end
    endtask

    task automatic test_key_load();
        do_reset();
        for (int i = 0; i < KEY_SIZE; i++) key_img[i] = 8'(i);
        write_key_img();
        @(negedge clk);
        bus.key_wr    = 1'b0;
        bus.key_start = 1'b1;
        for (int n = 0; n < KEY_SIZE; n++) begin
            @(negedge clk);
            bus.key_start = 1'b0;
            #1;
            tests++; if (bus.core_rst !== 1'b0 || bus.core_pw !== 8'(n) || bus.busy !== 1'b1) begin fails++; $display("FAIL load_cycle%0d: got core_rst=%b core_pw=%h busy=%b expected 0 %h 1", n, bus.core_rst, bus.core_pw, bus.busy, 8'(n)); end
        end
        repeat (1 + $urandom_range(0, 20)) begin
            @(negedge clk);
            #1;
            tests++; if (bus.core_rst !== 1'b0 || bus.core_pw !== 8'h00 || bus.busy !== 1'b1 || bus.ready !== 1'b0) begin fails++; $display("FAIL wait_state: got core_rst=%b core_pw=%h busy=%b ready=%b expected 0 00 1 0", bus.core_rst, bus.core_pw, bus.busy, bus.ready); end
        end
        bus.core_ready = 1'b1;
        bus.core_k     = 10'h3C5;
        @(negedge clk);
        bus.core_ready = 1'b0;
        #1;
        tests++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL wait_to_run: got ready=%b busy=%b expected 1 0", bus.ready, bus.busy); end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_g;
        bring_up(10'd1);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            bus.core_ready = 1'b0;
            bus.req        = 2'b11;
            exp_g          = (j % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            tests++; if (bus.gnt !== exp_g || bus.ks_data !== KW'(j + 1)) begin fails++; $display("FAIL arb_grant%0d: got gnt=%b ks=%0d expected %b %0d", j, bus.gnt, bus.ks_data, exp_g, j + 1); end
            @(negedge clk);
            bus.core_ready = 1'b1;
            bus.core_k     = KW'(j + 2);
            #1;
            tests++; if (bus.gnt !== 2'b00) begin fails++; $display("FAIL arb_empty%0d: got gnt=%b expected 00", j, bus.gnt); end
        end
    endtask

    task automatic test_overflow();
        bring_up(10'd1);
        for (int w = 2; w <= 9; w++) begin
            @(negedge clk);
            bus.core_ready = 1'b1;
            bus.core_k     = KW'(w);
            bus.req        = '0;
            #1;
            tests++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL ovf_early_w%0d: got %b expected 0", w, bus.ovf); end
        end
        for (int r = 1; r <= FIFO_DEPTH; r++) begin
            @(negedge clk);
            bus.core_ready = 1'b0;
            bus.req        = 2'b01;
            #1;
            tests++; if (bus.gnt !== 2'b01 || bus.ks_data !== KW'(r) || bus.ovf !== 1'b1) begin fails++; $display("FAIL ovf_drain%0d: got gnt=%b ks=%0d ovf=%b expected 01 %0d 1", r, bus.gnt, bus.ks_data, bus.ovf, r); end
        end
        @(negedge clk);
        #1;
        tests++; if (bus.gnt !== 2'b00 || bus.ovf !== 1'b1) begin fails++; $display("FAIL ovf_lost_word: got gnt=%b ovf=%b expected 00 1", bus.gnt, bus.ovf); end
    endtask

    // Continues from test_overflow: RUN, FIFO empty, ovf set.
    task automatic test_rekey();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req        = '0;
            bus.core_ready = 1'b1;
            bus.core_k     = KW'(10'h100 + i);
        end
        @(negedge clk);
        bus.core_ready = 1'b0;
        for (int i = 0; i < KEY_SIZE; i++) key_img[i] = 8'($urandom);
        write_key_img();
        @(negedge clk);
        bus.key_wr    = 1'b0;
        bus.key_start = 1'b1;
        @(negedge clk);
        bus.key_start = 1'b0;
        #1;
        tests++; if (bus.core_rst !== 1'b1 || bus.ovf !== 1'b0 || bus.ready !== 1'b0) begin fails++; $display("FAIL rekey_pulse: got core_rst=%b ovf=%b ready=%b expected 1 0 0", bus.core_rst, bus.ovf, bus.ready); end
        for (int n = 0; n < KEY_SIZE; n++) begin
            @(negedge clk);
            #1;
            tests++; if (bus.core_rst !== 1'b0 || bus.core_pw !== key_img[n]) begin fails++; $display("FAIL rekey_load%0d: got core_rst=%b core_pw=%h expected 0 %h", n, bus.core_rst, bus.core_pw, key_img[n]); end
        end
        @(negedge clk);
        bus.core_ready = 1'b1;
        bus.core_k     = 10'h2AA;
        @(negedge clk);
        bus.core_ready = 1'b0;
        bus.req        = 2'b01;
        #1;
        tests++; if (bus.gnt !== 2'b01 || bus.ks_data !== 10'h2AA) begin fails++; $display("FAIL rekey_flushed_head: got gnt=%b ks=%h expected 01 2aa", bus.gnt, bus.ks_data); end
        @(negedge clk);
        #1;
        tests++; if (bus.gnt !== 2'b00) begin fails++; $display("FAIL rekey_flushed_empty: got gnt=%b expected 00", bus.gnt); end
        bus.req = '0;
    endtask

    task automatic test_partial_key();
        logic [7:0] first_key [KEY_SIZE];
        do_reset();
        for (int i = 0; i < KEY_SIZE; i++) first_key[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.key_wr   = 1'b1;
            bus.key_data = first_key[i];
        end
        @(negedge clk);
        bus.key_wr    = 1'b0;
        bus.key_start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            bus.key_start = 1'b0;
            #1;
            tests++; if (bus.core_rst !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL partial_ignored: got core_rst=%b busy=%b expected 1 0", bus.core_rst, bus.busy); end
        end
        // Complete the key, then two surplus bytes that must be dropped.
        for (int i = 5; i < KEY_SIZE + 2; i++) begin
            @(negedge clk);
            bus.key_wr   = 1'b1;
            bus.key_data = (i < KEY_SIZE) ? first_key[i] : 8'hEE;
        end
        @(negedge clk);
        bus.key_wr    = 1'b0;
        bus.key_start = 1'b1;
        // Writes during LOAD must not land in the buffer.
        for (int n = 0; n < KEY_SIZE; n++) begin
            @(negedge clk);
            bus.key_start = 1'b0;
            bus.key_wr    = 1'b1;
            bus.key_data  = 8'hEE;
            #1;
            tests++; if (bus.core_rst !== 1'b0 || bus.core_pw !== first_key[n]) begin fails++; $display("FAIL full_key_load%0d: got core_rst=%b core_pw=%h expected 0 %h", n, bus.core_rst, bus.core_pw, first_key[n]); end
        end
        // Stage a second key while waiting for the core, then rekey from WAIT.
        for (int i = 0; i < KEY_SIZE; i++) key_img[i] = 8'($urandom);
        write_key_img();
        @(negedge clk);
        bus.key_wr    = 1'b0;
        bus.key_start = 1'b1;
        @(negedge clk);
        bus.key_start = 1'b0;
        #1;
        tests++; if (bus.core_rst !== 1'b1) begin fails++; $display("FAIL wait_rekey_pulse: got core_rst=%b expected 1", bus.core_rst); end
        for (int n = 0; n < KEY_SIZE; n++) begin
            @(negedge clk);
            #1;
            tests++; if (bus.core_rst !== 1'b0 || bus.core_pw !== key_img[n]) begin fails++; $display("FAIL wait_rekey_load%0d: got core_rst=%b core_pw=%h expected 0 %h", n, bus.core_rst, bus.core_pw, key_img[n]); end
        end
`ifdef RC4_KS_SCHED_TIMEOUT_EN
        for (int c = 0; c < TIMEOUT_CYC; c++) begin
            @(negedge clk);
            #1;
            if (c == 0 || c == TIMEOUT_CYC - 1) begin
                tests++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL wd_waiting_c%0d: got err=%b busy=%b expected 0 1", c, bus.err, bus.busy); end
            end
        end
        @(negedge clk);
        #1;
        tests++; if (bus.err !== 1'b1 || bus.core_rst !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL wd_expired: got err=%b core_rst=%b busy=%b expected 1 1 0", bus.err, bus.core_rst, bus.busy); end
`else
        repeat (200) @(negedge clk);
        #1;
        tests++; if (bus.err !== 1'b0 || bus.busy !== 1'b1 || bus.core_rst !== 1'b0) begin fails++; $display("FAIL wait_forever: got err=%b busy=%b core_rst=%b expected 0 1 0", bus.err, bus.busy, bus.core_rst); end
`endif
    endtask

    task automatic test_random();
        logic [KW-1:0]   q [$];
        logic [KW-1:0]   first;
        logic [KW-1:0]   k;
        logic [KW-1:0]   head;
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] exp_g;
        logic            cr;
        logic            full_m;
        logic            ovf_m;
        int              rr_m;
        int              gi;

        first = KW'($urandom);
        bring_up(first);
        q.push_back(first);
        rr_m  = 0;
        ovf_m = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            cr = ($urandom_range(0, 99) < 55);
            k  = KW'($urandom);
            if ((cyc / 150) % 2 == 0) r = NREQ'($urandom);
            else r = ($urandom_range(0, 7) == 0) ? NREQ'($urandom) : '0;
            @(negedge clk);
            bus.core_ready = cr;
            bus.core_k     = k;
            bus.req        = r;
            #1;
            exp_g = '0;
            gi    = 0;
            if (q.size() > 0) begin
                for (int i = 0; i < NREQ; i++) begin
                    int c;
                    c = (rr_m + i) % NREQ;
                    if (exp_g == '0 && r[c]) begin
                        exp_g = NREQ'(1) << c;
                        gi    = c;
                    end
                end
            end
            tests++; if (bus.gnt !== exp_g) begin fails++; $display("FAIL rand_gnt_c%0d: got %b expected %b", cyc, bus.gnt, exp_g); end
            if (exp_g != '0) begin
                tests++; if (bus.ks_data !== q[0]) begin fails++; $display("FAIL rand_ks_c%0d: got %h expected %h", cyc, bus.ks_data, q[0]); end
            end
            tests++; if (bus.ovf !== ovf_m) begin fails++; $display("FAIL rand_ovf_c%0d: got %b expected %b", cyc, bus.ovf, ovf_m); end
            full_m = (q.size() == FIFO_DEPTH);
            if (exp_g != '0) begin
                head = q.pop_front();
                rr_m = (gi + 1) % NREQ;
            end
            if (cr) begin
                if (!full_m || exp_g != '0) q.push_back(k);
                else ovf_m = 1'b1;
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_key_load();
        test_arbitration();
        test_overflow();
        test_rekey();
        test_partial_key();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
